// File: rtl/dac_ad5541_pkg.sv
// Shared constants for the AD5541 playback engine: register map, bit fields, FSM states.
package dac_ad5541_pkg;

    localparam int SAMPLE_W     = 16;
    localparam int SHIFT_CYCLES = 32;
    localparam int FRAME_LEN    = 37;

    localparam logic [11:0] ADDR_CTRL   = 12'h800;
    localparam logic [11:0] ADDR_LENGTH = 12'h803;
    localparam logic [11:0] ADDR_STATUS = 12'h804;
    localparam logic [11:0] ADDR_STATE  = 12'h805;
    localparam logic [11:0] ADDR_PERIOD = 12'h806;

    localparam logic [11:0] LENGTH_RST = 12'd5;

    localparam int CTRL_START = 0;
    localparam int CTRL_SRST  = 1;
    localparam int CTRL_LOOP  = 2;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_FETCH = 4'd1,
        ST_LOAD  = 4'd2,
        ST_SHIFT = 4'd3,
        ST_CSH   = 4'd4,
        ST_LDAC  = 4'd5,
        ST_WAIT  = 4'd6,
        ST_END   = 4'd7
    } state_t;

endpackage

// File: rtl/dac_sample_ram.sv
// Sample store: simple dual-port RAM, synchronous write, registered read (read-before-write).
module dac_sample_ram
    import dac_ad5541_pkg::*;
#(
    parameter int AW = 11
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic [SAMPLE_W-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic [SAMPLE_W-1:0] rdata
);
    logic [SAMPLE_W-1:0] mem [0:(1<<AW)-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/dac_ad5541_player.sv
// AD5541 playback engine: OPB register/RAM front end, frame sequencer and serial shifter.
module dac_ad5541_player
    import dac_ad5541_pkg::*;
#(
    parameter int          RAM_AW     = 11,
    parameter logic [15:0] PERIOD_RST = 16'd320
) (
    input  logic        OPB_CLK,
    input  logic        OPB_RST,
    input  logic [11:0] OPB_ADDR,
    input  logic [15:0] OPB_DI,
    input  logic        OPB_WE,
    input  logic        OPB_RE,
    output logic [31:0] OPB_DO,
    output logic        DA_CS_N,
    output logic        DA_SCLK,
    output logic        DA_DIN,
    output logic        DA_LDAC_N
);
    logic [2:0]          ctrl;
    logic [11:0]         length;
    logic [15:0]         period;
    logic [15:0]         period_m1;
    logic                busy, done, underrun;
    state_t              state, state_nx;
    logic [4:0]          cnt, cnt_nx;
    logic [RAM_AW-1:0]   rd_ptr, ptr_nx;
    logic [15:0]         per_cnt;
    logic                late;
    logic [SAMPLE_W-1:0] ram_q;
    logic [SAMPLE_W-1:0] shreg;
    logic                ram_we, ctrl_wr, len_wr, per_wr, srst;
    logic                last, leave, reload, kick, flag_under;
    logic                cs_n_nx, sclk_nx, din_nx, ldac_n_nx;
    logic                reg_sel;
    logic [31:0]         reg_rdata;

    assign ram_we    = OPB_WE && !OPB_ADDR[11];
    assign ctrl_wr   = OPB_WE && (OPB_ADDR == ADDR_CTRL);
    assign len_wr    = OPB_WE && (OPB_ADDR == ADDR_LENGTH);
    assign per_wr    = OPB_WE && (OPB_ADDR == ADDR_PERIOD);
    assign srst      = ctrl[CTRL_SRST];
    assign period_m1 = (period == 16'd0) ? 16'd0 : period - 16'd1;
    assign last      = (12'(rd_ptr) == length - 12'd1);

    dac_sample_ram #(.AW(RAM_AW)) u_ram (
        .clk   (OPB_CLK),
        .we    (ram_we),
        .waddr (OPB_ADDR[RAM_AW-1:0]),
        .wdata (OPB_DI),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        ptr_nx     = rd_ptr;
        reload     = 1'b0;
        kick       = 1'b0;
        leave      = 1'b0;
        flag_under = 1'b0;
        cs_n_nx    = 1'b1;
        sclk_nx    = 1'b0;
        din_nx     = 1'b0;
        ldac_n_nx  = 1'b1;
        case (state)
            ST_IDLE: begin
                if (ctrl[CTRL_START]) begin
                    kick = 1'b1;
                    if (length == 12'd0) begin
                        state_nx = ST_END;
                    end else begin
                        state_nx = ST_FETCH;
                        ptr_nx   = '0;
                        reload   = 1'b1;
                    end
                end
            end
            ST_FETCH: state_nx = ST_LOAD;
            ST_LOAD: begin
                state_nx = ST_SHIFT;
                cnt_nx   = '0;
                cs_n_nx  = 1'b0;
                din_nx   = ram_q[SAMPLE_W-1];
            end
            ST_SHIFT: begin
                if (cnt == 5'(SHIFT_CYCLES - 1)) begin
                    state_nx = ST_CSH;
                end else begin
                    // Odd cycles hold SCLK high; leaving one is the falling edge where DIN advances.
                    cnt_nx  = cnt + 5'd1;
                    cs_n_nx = 1'b0;
                    sclk_nx = ~cnt[0];
                    din_nx  = cnt[0] ? shreg[SAMPLE_W-2] : DA_DIN;
                end
            end
            ST_CSH: begin
                state_nx  = ST_LDAC;
                cnt_nx    = '0;
                ldac_n_nx = 1'b0;
            end
            ST_LDAC: begin
                if (cnt == 5'd0) begin
                    cnt_nx    = 5'd1;
                    ldac_n_nx = 1'b0;
                end else if (per_cnt == 16'd0) begin
                    // Deadline reached inside the frame: skip WAIT; flag only if it was missed.
                    leave      = 1'b1;
                    flag_under = late;
                end else begin
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: leave = (per_cnt == 16'd0);
            ST_END:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
        if (leave) begin
            if (!ctrl[CTRL_START] || (last && !ctrl[CTRL_LOOP])) begin
                state_nx = ST_END;
            end else begin
                state_nx = ST_FETCH;
                reload   = 1'b1;
                ptr_nx   = last ? '0 : rd_ptr + RAM_AW'(1);
            end
        end
    end

    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            rd_ptr    <= '0;
            per_cnt   <= '0;
            late      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            underrun  <= 1'b0;
            DA_CS_N   <= 1'b1;
            DA_SCLK   <= 1'b0;
            DA_DIN    <= 1'b0;
            DA_LDAC_N <= 1'b1;
        end else if (srst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            underrun  <= 1'b0;
            DA_CS_N   <= 1'b1;
            DA_SCLK   <= 1'b0;
            DA_DIN    <= 1'b0;
            DA_LDAC_N <= 1'b1;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            rd_ptr    <= ptr_nx;
            DA_CS_N   <= cs_n_nx;
            DA_SCLK   <= sclk_nx;
            DA_DIN    <= din_nx;
            DA_LDAC_N <= ldac_n_nx;
            // late marks a counter that sat at zero for a whole cycle before being consumed.
            if (reload) begin
                per_cnt <= period_m1;
                late    <= 1'b0;
            end else if (per_cnt != 16'd0) begin
                per_cnt <= per_cnt - 16'd1;
            end else begin
                late <= 1'b1;
            end
            if (kick) begin
                busy     <= (length != 12'd0);
                done     <= 1'b0;
                underrun <= 1'b0;
            end
            if (flag_under)
                underrun <= 1'b1;
            if (state == ST_END) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            ctrl   <= '0;
            length <= LENGTH_RST;
            period <= PERIOD_RST;
        end else begin
            if (ctrl_wr) begin
                ctrl <= OPB_DI[2:0];
            end else begin
                if (srst)
                    ctrl[CTRL_SRST] <= 1'b0;
                if (state == ST_END)
                    ctrl[CTRL_START] <= 1'b0;
            end
            if (len_wr)
                length <= OPB_DI[11:0];
            if (per_wr)
                period <= OPB_DI;
        end
    end

    always_ff @(posedge OPB_CLK) begin
        if (state == ST_LOAD)
            shreg <= ram_q;
        else if (state == ST_SHIFT && cnt[0])
            shreg <= {shreg[SAMPLE_W-2:0], 1'b0};
    end

    always_comb begin
        reg_sel   = 1'b1;
        reg_rdata = '0;
        case (OPB_ADDR)
            ADDR_CTRL:   reg_rdata = {29'd0, ctrl};
            ADDR_LENGTH: reg_rdata = {20'd0, length};
            ADDR_STATUS: reg_rdata = {29'd0, underrun, done, busy};
            ADDR_STATE:  reg_rdata = {28'd0, state};
            ADDR_PERIOD: reg_rdata = {16'd0, period};
            default:     reg_sel   = 1'b0;
        endcase
    end

    assign OPB_DO = (OPB_RE && reg_sel) ? reg_rdata : 32'bz;

endmodule
